// File: rtl/instr_mem_arbiter.sv
// rtl/instr_mem_arbiter.sv - two-port arbiter (fetch/loader) onto a single-port instruction memory
module instr_mem_arbiter #(
    parameter int DEPTH      = 16,
    parameter int STARVE_MAX = 4
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   f_req,
    input  logic [63:0]                            f_addr,
    output logic                                   f_gnt,
    output logic                                   f_rvalid,
    output logic [31:0]                            f_rdata,
    output logic                                   f_err,
    input  logic                                   l_req,
    input  logic                                   l_we,
    input  logic                                   l_lock,
    input  logic [63:0]                            l_addr,
    input  logic [31:0]                            l_wdata,
    output logic                                   l_gnt,
    output logic                                   l_rvalid,
    output logic [31:0]                            l_rdata,
    output logic                                   l_err,
    output logic                                   mem_en,
    output logic                                   mem_we,
    output logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0] mem_idx,
    output logic [31:0]                            mem_wdata,
    input  logic [31:0]                            mem_rdata,
    output logic                                   locked
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t          state;
    logic [SW-1:0]   starve_cnt;
    logic            f_gnt_c, l_gnt_c;
    logic            f_ok, l_ok;
    logic            f_acc, l_acc;
    logic            f_rvalid_q, f_err_q, f_rd_q;
    logic            l_rvalid_q, l_err_q, l_rd_q;

    // Range check on the full word index so high address bits cannot alias into the array.
    assign f_ok = (f_addr[1:0] == 2'b00) && ({2'b00, f_addr[63:2]} < 64'(DEPTH));
    assign l_ok = (l_addr[1:0] == 2'b00) && ({2'b00, l_addr[63:2]} < 64'(DEPTH));

    always_comb begin
        f_gnt_c = 1'b0;
        l_gnt_c = 1'b0;
        if (rst_n) begin
            if (state == LOCKED) begin
                l_gnt_c = l_req;
            end else if (f_req && (!l_req || starve_cnt == SW'(STARVE_MAX))) begin
                f_gnt_c = 1'b1;
            end else begin
                l_gnt_c = l_req;
            end
        end
    end

    assign f_acc = f_gnt_c && f_ok;
    assign l_acc = l_gnt_c && l_ok;

    assign f_gnt     = f_gnt_c;
    assign l_gnt     = l_gnt_c;
    assign mem_en    = f_acc || l_acc;
    assign mem_we    = l_acc && l_we;
    assign mem_wdata = l_acc ? l_wdata : 32'h0;
    assign mem_idx   = l_acc ? l_addr[IW+1:2] : (f_acc ? f_addr[IW+1:2] : '0);

    // Read data comes straight from the memory in the response cycle; writes and errors return zero.
    assign f_rvalid = f_rvalid_q;
    assign f_err    = f_err_q;
    assign f_rdata  = (f_rvalid_q && f_rd_q) ? mem_rdata : 32'h0;
    assign l_rvalid = l_rvalid_q;
    assign l_err    = l_err_q;
    assign l_rdata  = (l_rvalid_q && l_rd_q) ? mem_rdata : 32'h0;
    assign locked   = (state == LOCKED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            starve_cnt <= '0;
            f_rvalid_q <= 1'b0;
            f_err_q    <= 1'b0;
            f_rd_q     <= 1'b0;
            l_rvalid_q <= 1'b0;
            l_err_q    <= 1'b0;
            l_rd_q     <= 1'b0;
        end else begin
            f_rvalid_q <= f_gnt_c;
            f_err_q    <= f_gnt_c && !f_ok;
            f_rd_q     <= f_acc;
            l_rvalid_q <= l_gnt_c;
            l_err_q    <= l_gnt_c && !l_ok;
            l_rd_q     <= l_acc && !l_we;
            case (state)
                IDLE: begin
                    if (f_req && !f_gnt_c) begin
                        if (starve_cnt != SW'(STARVE_MAX)) begin
                            starve_cnt <= starve_cnt + SW'(1);
                        end
                    end else begin
                        starve_cnt <= '0;
                    end
                    if (l_lock) begin
                        state <= LOCKED;
                    end
                end
                LOCKED: begin
                    starve_cnt <= '0;
                    if (!l_lock) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state      <= IDLE;
                    starve_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/instr_mem_arbiter.md
INSTR_MEM_ARBITER -- requirements
Module: instr_mem_arbiter

Interface
REQ-001 The block SHALL have parameters:
- DEPTH, default 16, number of 32-bit words in the shared instruction memory.
- STARVE_MAX, default 4, number of consecutive denied fetch cycles before fetch is forced to win.
REQ-002 The block SHALL have these ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- f_req  in  1  fetch read request.
- f_addr  in  64  fetch byte address (PC).
- f_gnt  out  1  fetch request accepted this cycle.
- f_rvalid  out  1  fetch response valid.
- f_rdata  out  32  fetch instruction.
- f_err  out  1  fetch error, qualified by f_rvalid.
- l_req  in  1  loader request.
- l_we  in  1  loader write (1) or read (0).
- l_lock  in  1  loader exclusive mode.
- l_addr  in  64  loader byte address.
- l_wdata  in  32  loader write data.
- l_gnt  out  1  loader request accepted.
- l_rvalid  out  1  loader response valid; also acknowledges writes.
- l_rdata  out  32  loader read data.
- l_err  out  1  loader error, qualified by l_rvalid.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write.
- mem_idx  out  clog2(DEPTH)  memory word index.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data, valid the cycle after mem_en.
- locked  out  1  FSM is in LOCKED.

Function
REQ-003 The word index SHALL be addr>>2. An address SHALL be invalid if addr[1:0]!=0 or (addr>>2)>=DEPTH.
REQ-004 Grants SHALL be combinational in the request cycle. At most one of f_gnt/l_gnt SHALL be asserted per cycle.
REQ-005 A granted valid request SHALL drive, in the same cycle:
- mem_en=1
- mem_idx=addr>>2
- mem_we=l_we for loader, mem_we=0 for fetch
- mem_wdata=l_wdata for loader, 0 otherwise.
REQ-006 A granted invalid request SHALL keep mem_en=0 and mem_we=0.
REQ-007 Every grant SHALL produce exactly one response pulse on the matching rvalid in the next cycle.
- Reads: rdata=mem_rdata.
- Writes and errors: rdata=0.
- err=1 only for invalid addresses.
- Fixed latency 1, no back-pressure.
REQ-008 rdata outputs SHALL be 0 whenever their rvalid is 0.
REQ-009 The FSM SHALL have two states, IDLE and LOCKED. Transitions are evaluated on each clk edge.
- IDLE -> LOCKED when l_lock=1.
- LOCKED -> IDLE when l_lock=0.
- locked=1 only in LOCKED.
REQ-010 In IDLE, arbitration SHALL give the loader priority.
- If f_req and l_req are both set, the loader is granted unless starve_cnt==STARVE_MAX; in that case fetch is granted.
REQ-011 starve_cnt SHALL be a saturating counter, 0..STARVE_MAX.
- Increments on each IDLE cycle with f_req=1 and f_gnt=0.
- Clears to 0 on f_gnt or when f_req=0.
REQ-012 In LOCKED, f_gnt SHALL be 0, starve_cnt SHALL be held at 0, and the loader SHALL be granted whenever l_req=1.
REQ-013 Lock entry SHALL be evaluated after arbitration.
- A fetch granted in the cycle l_lock rises still completes its response.
- Lock exit re-enables fetch from the next cycle.
REQ-014 A single requester with no competition SHALL be granted in the same cycle in IDLE.
REQ-015 Addresses beyond 64-bit index truncation SHALL NOT alias. The range check uses the full addr>>2 value.

Reset
REQ-016 While rst_n=0, the block SHALL hold:
- FSM=IDLE, starve_cnt=0.
- All response registers cleared.
- f_gnt, l_gnt, mem_en, mem_we, f_rvalid, l_rvalid, f_err, l_err, locked = 0.
- f_rdata, l_rdata, mem_wdata, mem_idx = 0.
REQ-017 Reset asserted mid-operation SHALL discard any pending response; no rvalid follows the release of reset.
REQ-018 The first grant SHALL be possible in the first cycle after rst_n deasserts.

Verification
REQ-019 The bench SHALL cover these scenarios:
- Fetch-only: f_req=1, f_addr=0x8 -> f_gnt same cycle, mem_idx=2, mem_en=1 -> next cycle f_rvalid=1, f_rdata=mem[2], f_err=0.
- Contention, STARVE_MAX=4: f_req and l_req held high -> l_gnt for 4 cycles, f_gnt on the 5th, then l_gnt resumes with starve_cnt=0.
- Errors: f_addr=0x6 -> f_err=1, f_rdata=0, mem_en=0. l_addr=0x40 (DEPTH=16) -> l_err=1.
- Lock: l_lock=1 with l_we=1, l_addr=0x4, l_wdata=0xDEADBEEF while f_req=1 -> mem_we=1, mem_idx=1, f_gnt=0 throughout lock. After unlock, fetch of 0x4 returns 0xDEADBEEF.
- Reset mid-read: grant a fetch, assert rst_n=0 before the next edge -> f_rvalid stays 0 and all outputs are 0.
- Simultaneous events: lock rise in the same cycle as a fetch grant -> that fetch response is still delivered and locked=1 in the next cycle.
